// File: rtl/ififo_seq_pkg.sv
// Shared types and constants for the input-FIFO sequencer.
package ififo_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush,
    StDone
  } state_e;

  localparam int unsigned DefaultDepth = 64;
  localparam int unsigned VecW         = 16;

endpackage

// File: rtl/ififo_seq_credit.sv
// Occupancy / in-flight credit counter: limits SRAM fetches to what the FIFO lanes can absorb.
module ififo_seq_credit #(
  parameter int unsigned depth = 64,
  parameter int unsigned OccW  = $clog2(depth + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr_i,
  input  logic            issue_i,
  input  logic            rd_i,
  output logic [OccW-1:0] occ_o,
  output logic            inflight_o,
  output logic            ok_o
);

  localparam logic [OccW:0] DepthC = (OccW + 1)'(depth);

  logic [OccW-1:0] occ_q;
  logic            inflight_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q      <= '0;
      inflight_q <= 1'b0;
    end else if (clr_i) begin
      occ_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      // The in-flight read lands in the FIFO the next cycle, so it becomes the write strobe.
      inflight_q <= issue_i;
      unique case ({inflight_q, rd_i})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign occ_o      = occ_q;
  assign inflight_o = inflight_q;
  assign ok_o       = ((OccW + 1)'(occ_q) + (OccW + 1)'(inflight_q)) < DepthC;

endmodule

// File: rtl/ififo_seq.sv
// Streams num_vec SRAM rows into the per-row input FIFOs under a credit limit.
// Optional stall counter port stall_cnt is built when IFIFO_SEQ_PERF_EN is defined.
module ififo_seq
  import ififo_seq_pkg::*;
#(
  parameter int unsigned row    = 8,
  parameter int unsigned bw     = 4,
  parameter int unsigned depth  = DefaultDepth,
  parameter int unsigned addr_w = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [addr_w-1:0] base_addr,
  input  logic [VecW-1:0]   num_vec,
  input  logic              exec_ready,
  output logic              sram_cen,
  output logic [addr_w-1:0] sram_addr,
  input  logic [row*bw-1:0] sram_rdata,
  output logic [row*bw-1:0] fifo_in,
  output logic              fifo_wr,
  output logic              fifo_rd,
  input  logic              fifo_full,
  output logic              busy,
  output logic              done,
`ifdef IFIFO_SEQ_PERF_EN
  output logic [31:0]       stall_cnt,
`endif
  output logic              err
);

  localparam int unsigned    OccW      = $clog2(depth + 1);
  localparam logic [VecW-1:0] FlushLast = VecW'(row - 1);

  state_e            state_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [addr_w-1:0] base_q;
  logic [VecW-1:0]   num_q;
  logic [VecW-1:0]   fetched_q;
  logic [VecW-1:0]   drained_q;
  logic [VecW-1:0]   flush_q;

  logic              run;
  logic              accept;
  logic              want_fetch;
  logic              credit_ok;
  logic              fetch_en;
  logic [OccW-1:0]   occ;

  assign run        = (state_q == StRun);
  assign accept     = start && (state_q == StIdle);
  assign want_fetch = run && (fetched_q < num_q);
  assign fetch_en   = want_fetch && credit_ok;

  ififo_seq_credit #(
    .depth (depth),
    .OccW  (OccW)
  ) u_credit (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (accept),
    .issue_i    (fetch_en),
    .rd_i       (fifo_rd),
    .occ_o      (occ),
    .inflight_o (fifo_wr),
    .ok_o       (credit_ok)
  );

  assign sram_cen  = ~fetch_en;
  assign sram_addr = base_q + addr_w'(fetched_q);
  assign fifo_in   = fifo_wr ? sram_rdata : '0;
  assign fifo_rd   = run && exec_ready && (occ != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q    <= '0;
      num_q     <= '0;
      fetched_q <= '0;
      drained_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        base_q    <= base_addr;
        num_q     <= num_vec;
        fetched_q <= '0;
        drained_q <= '0;
      end else begin
        if (fetch_en) fetched_q <= fetched_q + 1'b1;
        if (fifo_rd)  drained_q <= drained_q + 1'b1;
      end
      if (fifo_wr && fifo_full) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      flush_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRun;
            busy_q  <= 1'b1;
          end
        end
        StRun: begin
          if (num_q == '0) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else if (fifo_rd && (drained_q + 1'b1 == num_q)) begin
            state_q <= StFlush;
            flush_q <= '0;
          end
        end
        // Hold off completion until the last lane's staggered read has left its FIFO.
        StFlush: begin
          if (flush_q == FlushLast) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            flush_q <= flush_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

`ifdef IFIFO_SEQ_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if (want_fetch && !credit_ok && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
